ripple_count_sampler: RTL and testbench

Synchronous capture stage placed directly downstream of the 6-bit ripple counter. Resynchronises the counter's asynchronous, rippling output bus into the system clock domain. Accepts a value only once it has settled. Delivers each accepted value over a valid/ready handshake, with single-cycle compare-match and wrap-around event pulses.

---
 rtl/ripple_count_sampler.sv | 130 +++++++++++++
 tb/tb_ripple_count_sampler.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/ripple_count_sampler.sv
// ripple_count_sampler: resynchronises a rippling counter bus,
// filters it for stability and hands settled values to a consumer.
module ripple_count_sampler #(
    parameter int WIDTH         = 6,
    parameter int STABLE_CYCLES = 3
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [WIDTH-1:0] count_in,
    input  logic [WIDTH-1:0] thresh,
    output logic [WIDTH-1:0] out_count,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             match,
    output logic             wrap,
    output logic             overrun,
    input  logic             ovr_clr
);

    typedef enum logic {
        EMPTY,
        FULL
    } state_t;

    localparam logic [3:0] STABLE = 4'(STABLE_CYCLES);

    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;
    logic [WIDTH-1:0] acc_q;
    logic [3:0]       run;
    logic [3:0]       run_n;
    logic             same;
    logic             accept;
    logic             load;
    logic             drop;
    state_t           state;
    state_t           state_n;

    // s1 is the value s2 takes at this edge, so compare it to s2
    always_comb begin
        same   = (s1 == s2);
        run_n  = 4'd0;
        if (same) begin
            run_n = (run == STABLE) ? STABLE : run + 4'd1;
        end
        accept = (run_n == STABLE) && (s1 != acc_q);
    end

    // one-entry buffer: load, hand off, or drop when the consumer stalls
    always_comb begin
        state_n = state;
        load    = 1'b0;
        drop    = 1'b0;
        unique case (state)
            EMPTY: begin
                if (accept) begin
                    load    = 1'b1;
                    state_n = FULL;
                end
            end
            FULL: begin
                if (out_ready) begin
                    if (accept) begin
                        load = 1'b1;
                    end else begin
                        state_n = EMPTY;
                    end
                end else if (accept) begin
                    drop = 1'b1;
                end
            end
            default: state_n = EMPTY;
        endcase
    end

    assign out_valid = (state == FULL);

    // buffer state register
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state <= EMPTY;
        end else begin
            state <= state_n;
        end
    end

    // two-flop synchroniser and stability run counter
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            s1  <= '0;
            s2  <= '0;
            run <= 4'd0;
        end else begin
            s1  <= count_in;
            s2  <= s1;
            run <= run_n;
        end
    end

    // accepted value, event pulses and delivered value
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            acc_q     <= '0;
            match     <= 1'b0;
            wrap      <= 1'b0;
            out_count <= '0;
        end else begin
            match <= accept && (s1 == thresh);
            wrap  <= accept && (s1 < acc_q);
            if (accept) begin
                acc_q <= s1;
            end
            if (load) begin
                out_count <= s1;
            end
        end
    end

    // sticky overrun; a fresh drop beats a clear in the same cycle
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            overrun <= 1'b0;
        end else if (drop) begin
            overrun <= 1'b1;
        end else if (ovr_clr) begin
            overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ripple_count_sampler.sv
// tb_ripple_count_sampler: directed checks of sampling, filtering,
// events and handshake of ripple_count_sampler.
module tb_ripple_count_sampler;

    logic       clk;
    logic       clr;
    logic [5:0] count_in;
    logic [5:0] thresh;
    logic [5:0] out_count;
    logic       out_valid;
    logic       out_ready;
    logic       match;
    logic       wrap;
    logic       overrun;
    logic       ovr_clr;

    int checks;
    int failures;

    int seen6;
    int ndeliv;
    int last_val;
    int nwrap;
    int nmatch;
    int wrap_cnt_bad;

    ripple_count_sampler #(
        .WIDTH(6),
        .STABLE_CYCLES(3)
    ) dut (
        .clk(clk),
        .clr(clr),
        .count_in(count_in),
        .thresh(thresh),
        .out_count(out_count),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .match(match),
        .wrap(wrap),
        .overrun(overrun),
        .ovr_clr(ovr_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // tick n times, logging deliveries and event pulses
    task automatic run_log(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            if (out_valid) begin
                ndeliv++;
                last_val = int'(out_count);
                if (out_count == 6'd6) seen6++;
            end
            if (wrap) begin
                nwrap++;
                if (out_count != 6'd0) wrap_cnt_bad++;
            end
            if (match) nmatch++;
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        clr       = 1'b0;
        count_in  = 6'h2A;
        thresh    = 6'h2A;
        out_ready = 1'b0;
        ovr_clr   = 1'b0;

        repeat (3) tick();
        check("rst_valid", int'(out_valid), 0);
        check("rst_count", int'(out_count), 0);
        check("rst_match", int'(match), 0);
        check("rst_wrap", int'(wrap), 0);
        check("rst_ovr", int'(overrun), 0);

        clr = 1'b1;
        repeat (4) tick();
        check("lat_valid_e4", int'(out_valid), 0);
        tick();
        check("lat_valid_e5", int'(out_valid), 1);
        check("lat_count", int'(out_count), 'h2A);
        check("lat_match", int'(match), 1);
        check("lat_wrap", int'(wrap), 0);

        out_ready = 1'b1;
        tick();
        check("drain_valid", int'(out_valid), 0);
        check("match_pulse", int'(match), 0);

        seen6    = 0;
        ndeliv   = 0;
        last_val = -1;
        nwrap    = 0;
        nmatch   = 0;
        count_in = 6'd5;
        run_log(8);
        count_in = 6'd6;
        run_log(2);
        count_in = 6'd7;
        run_log(8);
        check("glitch_seen6", seen6, 0);
        check("glitch_ndeliv", ndeliv, 2);
        check("glitch_last", last_val, 7);

        thresh   = 6'h00;
        nwrap    = 0;
        nmatch   = 0;
        count_in = 6'h3F;
        run_log(10);
        check("w3f_wrap", nwrap, 0);
        check("w3f_match", nmatch, 0);
        wrap_cnt_bad = 0;
        count_in = 6'h00;
        run_log(10);
        check("w00_wrap", nwrap, 1);
        check("w00_match", nmatch, 1);
        check("w00_count", wrap_cnt_bad, 0);

        out_ready = 1'b0;
        count_in  = 6'd1;
        repeat (8) tick();
        check("bp1_valid", int'(out_valid), 1);
        check("bp1_count", int'(out_count), 1);
        check("bp1_ovr", int'(overrun), 0);
        count_in = 6'd2;
        repeat (8) tick();
        check("bp2_valid", int'(out_valid), 1);
        check("bp2_count", int'(out_count), 1);
        check("bp2_ovr", int'(overrun), 1);
        ovr_clr = 1'b1;
        tick();
        ovr_clr = 1'b0;
        check("ovr_clr", int'(overrun), 0);
        out_ready = 1'b1;
        tick();
        check("bp_empty", int'(out_valid), 0);

        out_ready = 1'b0;
        count_in  = 6'd8;
        repeat (8) tick();
        check("s8_count", int'(out_count), 8);
        count_in = 6'd9;
        repeat (4) tick();
        check("s9_hold", int'(out_count), 8);
        out_ready = 1'b1;
        tick();
        check("s9_count", int'(out_count), 9);
        check("s9_valid", int'(out_valid), 1);
        check("s9_ovr", int'(overrun), 0);

        out_ready = 1'b0;
        count_in  = 6'd10;
        repeat (4) tick();
        ovr_clr = 1'b1;
        tick();
        ovr_clr = 1'b0;
        check("sim_ovr_set", int'(overrun), 1);
        check("sim_count", int'(out_count), 9);

        #2;
        clr = 1'b0;
        #1;
        check("mid_valid", int'(out_valid), 0);
        check("mid_count", int'(out_count), 0);
        check("mid_ovr", int'(overrun), 0);
        tick();
        check("mid_hold", int'(out_valid), 0);
        clr = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
